// File: rtl/soc_io_pkg.sv
// Shared IO definitions for the SoC peripheral slice: address decode bits,
// UART status word layout and transmit controller state encoding.
package soc_io_pkg;

  localparam int unsigned IO_LEDS_EN  = 0;
  localparam int unsigned IO_UART_DAT = 1;
  localparam int unsigned IO_UART_CTL = 2;

  localparam int unsigned STAT_LVL_LSB = 0;
  localparam int unsigned STAT_EMPTY   = 8;
  localparam int unsigned STAT_FULL    = 9;
  localparam int unsigned STAT_BUSY    = 10;
  localparam int unsigned STAT_OVF     = 11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers; level counts stored
// entries only. clear discards contents by snapping rd_ptr to wr_ptr.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  input  logic             clear
);

  localparam int unsigned AW = LVL_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LVL_W-1:0] wr_ptr;
  logic [LVL_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // clear takes priority over both a write and a read in the same cycle
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (clear)
        rd_ptr <= wr_ptr;
      else if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmit controller: buffers CPU byte writes and drains
// them into uart_tx over valid/ready, exposing a 32-bit status word.
module uart_tx_ctrl
  import soc_io_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        tx_en,
  input  logic        flush,
  input  logic        ovf_clr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] status,
  output logic        busy
);

  tx_state_e        state;
  tx_state_e        state_nx;
  logic             pop;
  logic             can_pop;
  logic             ovf;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic [7:0]       fifo_dout;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level),
    .clear (flush)
  );

  // flush in the same cycle suppresses the pop, as if the FIFO were empty
  assign can_pop = tx_en & ~empty & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    tx_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_pop) begin
          pop      = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (can_pop)
            pop = 1'b1;
          else
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tx_data <= '0;
    else if (pop)
      tx_data <= fifo_dout;
  end

  // full is the pre-edge value, so a same-cycle pop does not rescue the write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ovf <= 1'b0;
    else if (wr_en & full & ~flush)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

  assign busy = tx_valid | ~tx_ready | ~empty;

  always_comb begin
    status                         = '0;
    status[STAT_LVL_LSB +: 8]      = 8'(level);
    status[STAT_EMPTY]             = empty;
    status[STAT_FULL]              = full;
    status[STAT_BUSY]              = busy;
    status[STAT_OVF]               = ovf;
  end

endmodule
